// File: rtl/imem_loader.sv
// imem_loader: writer side of the Y86 instruction memory.
// Accepts a framed byte stream (LEN_LO, LEN_HI, N payload bytes, CSUM),
// writes the payload from BASE_ADDR upward, verifies the mod-256 checksum
// and releases the CPU from reset only after a good frame.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i           1-cycle pulse arming the loader for a new frame
//   byte_i            stream byte
//   byte_valid_i      byte_i valid
//   byte_ready_o      loader accepts byte_i this cycle (decoded from state)
//   imem_we_o         instruction memory write strobe (registered)
//   imem_addr_o       write byte address (registered)
//   imem_wdata_o      write byte (registered)
//   load_done_o       frame loaded and checksum good
//   load_err_o        frame rejected (length or checksum)
//   cpu_rst_o         holds the CPU in reset while high
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [7:0]        imem_wdata_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic              cpu_rst_o
);

    // Largest payload that fits between BASE_ADDR and the top of memory.
    localparam int unsigned MAX_LEN = (32'd1 << ADDR_W) - BASE_ADDR;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] count;
    logic [7:0]  sum;

    logic        acc;
    logic [15:0] len_rx;
    logic [15:0] count_nx;

    // Ready depends on state only, so the source never sees a combinational loop.
    assign byte_ready_o = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                          (state == S_DATA)   || (state == S_CSUM);
    assign acc      = byte_valid_i & byte_ready_o;
    assign len_rx   = {byte_i, len_lo};
    assign count_nx = count + 16'd1;

    // Frame sequencer with registered write port and status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            count        <= 16'd0;
            sum          <= 8'd0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= 8'd0;
            load_done_o  <= 1'b0;
            load_err_o   <= 1'b0;
            cpu_rst_o    <= 1'b1;
        end else begin
            imem_we_o <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state       <= S_LEN_LO;
                        sum         <= 8'd0;
                        count       <= 16'd0;
                        load_done_o <= 1'b0;
                        load_err_o  <= 1'b0;
                        cpu_rst_o   <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (acc) begin
                        len_lo <= byte_i;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (acc) begin
                        len <= len_rx;
                        if (32'(len_rx) > MAX_LEN) begin
                            state      <= S_ERR;
                            load_err_o <= 1'b1;
                        end else if (len_rx == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (acc) begin
                        imem_we_o    <= 1'b1;
                        imem_addr_o  <= ADDR_W'(BASE_ADDR) + ADDR_W'(count);
                        imem_wdata_o <= byte_i;
                        sum          <= sum + byte_i;
                        count        <= count_nx;
                        if (count_nx == len) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (acc) begin
                        if (byte_i == sum) begin
                            state       <= S_DONE;
                            load_done_o <= 1'b1;
                            cpu_rst_o   <= 1'b0;
                        end else begin
                            state      <= S_ERR;
                            load_err_o <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized frames against a frame-level
// reference model (expected write list, expected done/err outcome).
module tb_imem_loader;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned BASE_ADDR = 0;
    localparam int unsigned MAX_LEN   = (32'd1 << ADDR_W) - BASE_ADDR;

    typedef logic [7:0] byte_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              imem_we_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [7:0]        imem_wdata_o;
    logic              load_done_o;
    logic              load_err_o;
    logic              cpu_rst_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_W+7:0] got_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o),
        .cpu_rst_o    (cpu_rst_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every write strobe seen, one entry per cycle.
    always @(negedge clk_i) begin
        if (imem_we_o) got_q.push_back({imem_addr_o, imem_wdata_o});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        check({tag, "_we"},    32'(imem_we_o),    32'd0);
        check({tag, "_addr"},  32'(imem_addr_o),  32'd0);
        check({tag, "_wdata"}, 32'(imem_wdata_o), 32'd0);
        check({tag, "_done"},  32'(load_done_o),  32'd0);
        check({tag, "_err"},   32'(load_err_o),   32'd0);
        check({tag, "_cpurst"},32'(cpu_rst_o),    32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start_i      = 1'b1;
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Drive bytes; gap_mode 0 = continuous, 1 = valid toggles, 2 = random gaps.
    // A start_i pulse is injected alongside byte index start_at (-1 = never).
    task automatic send_bytes(input byte_t fb[$], input int gap_mode, input int start_at,
                              output bit ok);
        bit tog;
        tog = 1'b1;
        ok  = 1'b1;
        for (int i = 0; i < fb.size(); i++) begin
            int waited;
            bit accepted;
            bit v;
            waited   = 0;
            accepted = 1'b0;
            while (!accepted) begin
                @(negedge clk_i);
                case (gap_mode)
                    0:       v = 1'b1;
                    1:       begin v = tog; tog = ~tog; end
                    default: v = ($urandom_range(0, 3) != 0);
                endcase
                byte_i       = fb[i];
                byte_valid_i = v;
                start_i      = (i == start_at) && (waited == 0);
                accepted     = v && byte_ready_o;
                @(posedge clk_i);
                waited++;
                if (!accepted && waited > 200) begin
                    check("ready_timeout", 32'd0, 32'd1);
                    ok = 1'b0;
                    return;
                end
            end
        end
    endtask

    // Arm, stream one frame, and compare against the frame-level model.
    task automatic run_frame(input string tag, input int n, input byte_t pay[$],
                             input byte_t csum, input int gap_mode, input int start_at);
        byte_t             fb[$];
        logic [ADDR_W+7:0] exp_q[$];
        bit                len_bad;
        bit                good;
        bit                ok;
        int                s;
        int                lim;

        len_bad = (n > int'(MAX_LEN));
        s = 0;
        if (!len_bad) begin
            for (int k = 0; k < n; k++) begin
                s = (s + int'(pay[k])) % 256;
                exp_q.push_back({ADDR_W'(BASE_ADDR + k), pay[k]});
            end
        end
        good = !len_bad && (int'(csum) == s);

        fb.push_back(byte_t'(n & 255));
        fb.push_back(byte_t'((n >> 8) & 255));
        if (!len_bad) begin
            for (int k = 0; k < n; k++) fb.push_back(pay[k]);
            fb.push_back(csum);
        end

        pulse_start();
        check({tag, "_arm_done"},   32'(load_done_o), 32'd0);
        check({tag, "_arm_err"},    32'(load_err_o),  32'd0);
        check({tag, "_arm_cpurst"}, 32'(cpu_rst_o),   32'd1);
        got_q.delete();

        send_bytes(fb, gap_mode, start_at, ok);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        start_i      = 1'b0;
        if (ok) begin
            check({tag, "_done"},   32'(load_done_o),  32'(good));
            check({tag, "_err"},    32'(load_err_o),   32'(!good));
            check({tag, "_cpurst"}, 32'(cpu_rst_o),    32'(!good));
            check({tag, "_ready"},  32'(byte_ready_o), 32'd0);
        end
        repeat (3) @(negedge clk_i);
        check({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < lim; k++) begin
            check($sformatf("%s_wr%0d", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
        end
        check({tag, "_hold_done"}, 32'(load_done_o), 32'(good));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_t pay[$];
        byte_t fb[$];
        bit    ok;

        rst_i        = 1'b1;
        start_i      = 1'b0;
        byte_i       = 8'd0;
        byte_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_i = 1'b0;

        // Basic frame, good checksum.
        pay = '{8'h30, 8'hF2, 8'h0A};
        run_frame("t1", 3, pay, 8'h2C, 0, -1);
        // Bad checksum: writes still happen, CPU stays in reset.
        run_frame("t2", 3, pay, 8'h00, 0, -1);

        // Length one past capacity, then exactly at capacity.
        pay.delete();
        run_frame("t3_over", int'(MAX_LEN) + 1, pay, 8'h00, 0, -1);
        for (int k = 0; k < int'(MAX_LEN); k++) pay.push_back(8'h01);
        run_frame("t3_full", int'(MAX_LEN), pay, 8'h00, 0, -1);

        // Empty frame, and valid toggling every cycle.
        pay.delete();
        run_frame("t4_empty", 0, pay, 8'h00, 0, -1);
        pay = '{8'h30, 8'hF2, 8'h0A};
        run_frame("t4_toggle", 3, pay, 8'h2C, 1, -1);

        // Reset after the first payload byte.
        pulse_start();
        fb = '{8'h03, 8'h00, 8'h30};
        send_bytes(fb, 0, -1, ok);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        rst_i        = 1'b1;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        got_q.delete();
        repeat (5) @(negedge clk_i);
        check("t5_nowr", 32'(got_q.size()), 32'd0);
        run_frame("t5_reload", 3, pay, 8'h2C, 0, -1);

        // start_i during payload is ignored; restart from DONE works.
        run_frame("t6_ign", 3, pay, 8'h2C, 0, 3);
        pay = '{8'h00};
        run_frame("t6_second", 1, pay, 8'h00, 0, -1);

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            int    n;
            int    s;
            byte_t cs;
            pay.delete();
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1100))
                                            : int'($urandom_range(0, 40));
            s = 0;
            for (int k = 0; k < n; k++) begin
                pay.push_back(byte_t'($urandom_range(0, 255)));
                s = (s + int'(pay[k])) % 256;
            end
            if ($urandom_range(0, 3) != 0) cs = byte_t'(s);
            else cs = byte_t'((s + int'($urandom_range(1, 255))) % 256);
            run_frame($sformatf("rnd%0d", f), n, pay, cs, int'($urandom_range(0, 2)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
